// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Accepts one ALU request at a time, decodes it into a 3-bit ALU control
//   code and produces a two-word result. Add, sub, AND, OR and illegal
//   requests complete on the accept edge. Multiply (shift-add) and divide
//   (restoring) iterate one bit per cycle for WIDTH cycles. The result is
//   held in DONE until the consumer takes it.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : sequencer idle and able to accept (low while in reset)
//   alu_op     : ALUop class (00 R-type, 01 ANDi, 10 ORi, 11 address add)
//   funct      : R-type function field
//   op_a, op_b : unsigned operands
//   rsp_valid  : result available
//   rsp_ready  : consumer accepts the result
//   result_lo  : low result word (quotient for divide)
//   result_hi  : high result word (remainder for divide)
//   ctrl_out   : decoded ALU control code of the last accepted request
//   err        : illegal funct or divide-by-zero, qualified by rsp_valid
//   busy       : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       ctrl_out,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_MUL = 3'b010;
    localparam logic [2:0] CTRL_DIV = 3'b011;
    localparam logic [2:0] CTRL_AND = 3'b100;
    localparam logic [2:0] CTRL_OR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvsr;

    logic [2:0]         dec_ctrl;
    logic               dec_illegal;
    logic               dec_mul;
    logic               dec_div;
    logic               div_by_zero;
    logic [WIDTH-1:0]   quick_lo;
    logic [WIDTH-1:0]   quick_hi;
    logic               quick_err;

    logic               accept;
    logic               last_step;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign accept    = req_valid && req_ready;
    assign last_step = (cnt == CW'(WIDTH - 1));

    // Request decode straight from the inputs; only used on the accept edge.
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (alu_op)
            2'b00: begin
                case (funct)
                    4'b0000: dec_ctrl = CTRL_ADD;
                    4'b0001: dec_ctrl = CTRL_SUB;
                    4'b0100: begin
                        dec_ctrl = CTRL_MUL;
                        dec_mul  = 1'b1;
                    end
                    4'b0101: begin
                        dec_ctrl = CTRL_DIV;
                        dec_div  = 1'b1;
                    end
                    default: begin
                        dec_ctrl    = CTRL_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            2'b01:   dec_ctrl = CTRL_AND;
            2'b10:   dec_ctrl = CTRL_OR;
            default: dec_ctrl = CTRL_ADD;
        endcase
    end

    assign div_by_zero = dec_div && (op_b == '0);

    // Results for everything that finishes on the accept edge. The illegal
    // case shares ctrl 000 with add, so it must override the adder result.
    always_comb begin
        quick_lo  = '0;
        quick_hi  = '0;
        quick_err = 1'b0;
        case (dec_ctrl)
            CTRL_ADD: quick_lo = op_a + op_b;
            CTRL_SUB: quick_lo = op_a - op_b;
            CTRL_AND: quick_lo = op_a & op_b;
            CTRL_OR:  quick_lo = op_a | op_b;
            default:  quick_lo = '0;
        endcase
        if (dec_illegal) begin
            quick_lo  = '0;
            quick_err = 1'b1;
        end
        if (div_by_zero) begin
            quick_lo  = '1;
            quick_hi  = op_a;
            quick_err = 1'b1;
        end
    end

    // One shift-add step: the multiplicand is pre-shifted so each step
    // simply adds it when the current multiplier LSB is set.
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    // One restoring-divide step: bring in the next dividend bit and keep the
    // difference only if it did not borrow.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvsr};
    assign div_fits  = ~div_diff[WIDTH];
    assign rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], div_fits};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Divide-by-zero skips the iteration entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_mul) begin
                        state_next = MUL;
                    end else if (dec_div && !div_by_zero) begin
                        state_next = DIV;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake/status outputs. req_ready is gated by rst_n so nothing can
    // look acceptable while reset is held.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                busy      = 1'b0;
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration and result registers. err is
    // cleared on the response handshake so it is never high without
    // rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            result_lo <= '0;
            result_hi <= '0;
            ctrl_out  <= 3'b000;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_out <= dec_ctrl;
                        cnt      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, op_a};
                        mplier   <= op_b;
                        prod     <= '0;
                        quo      <= op_a;
                        rem      <= '0;
                        dvsr     <= op_b;
                        err      <= 1'b0;
                        if (!dec_mul && !(dec_div && !div_by_zero)) begin
                            result_lo <= quick_lo;
                            result_hi <= quick_hi;
                            err       <= quick_err;
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        result_lo <= prod_next[WIDTH-1:0];
                        result_hi <= prod_next[2*WIDTH-1:WIDTH];
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        result_lo <= quo_next;
                        result_hi <= rem_next;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 WIDTH, 16, operand/result width in bits; counter width SHALL be clog2(WIDTH)+1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 alu_op  input  2  ALUop class (00 R-type, 01 ANDi, 10 ORi, 11 load/store address).
REQ-007 funct  input  4  R-type function field.
REQ-008 op_a, op_b  input  WIDTH each  operands, unsigned.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 result_lo, result_hi  output  WIDTH each  low/high result words.
REQ-012 ctrl_out  output  3  decoded ALU control code of the accepted op.
REQ-013 err  output  1  illegal funct or divide-by-zero, valid with rsp_valid.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, MUL, DIV, DONE; req_ready SHALL equal (state==IDLE).
REQ-016 Accept occurs on req_valid && req_ready; alu_op, funct, op_a, op_b SHALL be captured at accept and later input changes ignored.
REQ-017 Decode: alu_op 00 with funct 0000 add (000), 0001 sub (001), 0100 mult (010), 0101 div (011); 01 AND (100); 10 OR (101); 11 add (000).
REQ-018 alu_op 00 with any other funct SHALL be illegal: ctrl_out 000, err 1, results 0.
REQ-019 Add/sub/AND/OR/illegal: IDLE->DONE at accept edge; rsp_valid high the cycle after accept; result_hi 0.
REQ-020 Add and sub SHALL wrap modulo 2^WIDTH; no carry/borrow reported.
REQ-021 Mult: IDLE->MUL; unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL; {result_hi,result_lo} = full 2*WIDTH product; rsp_valid WIDTH+1 cycles after accept.
REQ-022 Div: IDLE->DIV; unsigned restoring, one quotient bit per cycle, exactly WIDTH cycles in DIV; result_lo quotient, result_hi remainder; rsp_valid WIDTH+1 cycles after accept.
REQ-023 Div with op_b==0: IDLE->DONE directly, rsp_valid next cycle, err 1, result_lo all ones, result_hi op_a.
REQ-024 DONE: rsp_valid, result_lo/hi, ctrl_out, err SHALL hold stable until rsp_valid && rsp_ready.
REQ-025 DONE->IDLE on handshake; rsp_valid drops and req_ready rises the next cycle; no same-cycle accept+response.
REQ-026 ctrl_out SHALL update at accept and hold until next accept.
REQ-027 rsp_valid SHALL be 0 in IDLE, MUL, DIV; err SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, rsp_valid 0, err 0, busy 0, result_lo/hi 0, ctrl_out 000, and req_ready 0 while rst_n is low.
REQ-029 Reset asserted mid-MUL/DIV/DONE SHALL abort the operation with no response; first accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 alu_op 00, funct 0001, op_a 0x0003, op_b 0x0005, rsp_ready 1 -> one cycle later rsp_valid 1, result_lo 0xFFFE, result_hi 0, ctrl_out 001, err 0.
REQ-031 funct 0100, op_a 0xFFFF, op_b 0xFFFF -> rsp_valid exactly 17 cycles after accept, result_hi 0xFFFE, result_lo 0x0001, busy high 17 cycles.
REQ-032 funct 0101, op_a 0x0064, op_b 0x0007 -> after 17 cycles result_lo 0x000E, result_hi 0x0002; repeat with op_b 0 -> after 1 cycle err 1, result_lo 0xFFFF, result_hi 0x0064.
REQ-033 funct 1111 -> err 1, ctrl_out 000, results 0; alu_op 01 op_a 0x0F0F op_b 0x00FF -> result_lo 0x000F, ctrl_out 100.
REQ-034 rsp_ready held 0 for 10 cycles in DONE while req_valid 1 and inputs toggle -> outputs stable, req_ready 0, no new accept until cycle after handshake.
REQ-035 rst_n pulsed low at cycle 8 of a mult -> rsp_valid never asserts, all outputs 0 immediately, next add request completes normally.
